// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam int FRAME_DATA_BITS = 8;

    // True when data plus parity carries an odd number of ones.
    function automatic logic odd_parity_ok(input logic [FRAME_DATA_BITS-1:0] data,
                                           input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous show-ahead FIFO. A push into a full FIFO lands only when a pop
// frees the head slot in the same cycle.
module ps2_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign count    = cnt;
    assign pop_data = empty ? '0 : mem[rptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 host receiver: synchronizes the device pins, deframes 11-bit frames on
// falling ps2_clk edges and queues good scan-code bytes.
//
// state  | meaning
// IDLE   | waiting for a start bit (falls with dat=1 are idle clocking)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking parity then stop bit; pushes good bytes
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_dat,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [7:0]                    rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          parity_err,
    output logic                          frame_err,
    input  logic                          err_clr
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int BW = $clog2(FRAME_DATA_BITS);
    localparam logic [TW-1:0] TLOAD    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_DATA_BITS - 1);

    logic [SYNC_STAGES-1:0]     clk_sync;
    logic [SYNC_STAGES-1:0]     dat_sync;
    logic                       prev_clk;
    logic                       sync_clk;
    logic                       sdat;
    logic                       fall;

    ps2_state_t                 state;
    logic [FRAME_DATA_BITS-1:0] shreg;
    logic [BW-1:0]              bitcnt;
    logic                       par_bit;
    logic [TW-1:0]              tcnt;

    logic                       in_stop_fall;
    logic                       par_ok;
    logic                       timeout_hit;
    logic                       push_req;
    logic                       perr_set;
    logic                       ferr_set;
    logic                       drop;
    logic                       fifo_full;
    logic                       fifo_empty;

    assign sync_clk = clk_sync[SYNC_STAGES-1];
    assign sdat     = dat_sync[SYNC_STAGES-1];
    assign fall     = prev_clk & ~sync_clk;

    assign in_stop_fall = fall & (state == STOP);
    assign par_ok       = odd_parity_ok(shreg, par_bit);
    // Timer is a down-counter reloaded on every fall; reaching zero means
    // TIMEOUT_CYCLES-1 cycles passed without an edge.
    assign timeout_hit  = (state != IDLE) & ~fall & (tcnt == '0);
    assign push_req     = in_stop_fall & sdat & par_ok;
    assign perr_set     = in_stop_fall & ~par_ok;
    assign ferr_set     = (in_stop_fall & par_ok & ~sdat) | timeout_hit;
    assign drop         = push_req & fifo_full & ~(rd_ready & ~fifo_empty);
    assign rd_valid     = ~fifo_empty;

    ps2_fifo #(
        .WIDTH (FRAME_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_req),
        .push_data (shreg),
        .pop       (rd_ready),
        .pop_data  (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync   <= '1;
            dat_sync   <= '1;
            prev_clk   <= 1'b1;
            state      <= IDLE;
            shreg      <= '0;
            bitcnt     <= '0;
            par_bit    <= 1'b0;
            tcnt       <= TLOAD;
            overflow   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
            prev_clk <= sync_clk;

            // A new error in the same cycle as err_clr keeps the flag set.
            overflow   <= (overflow   & ~err_clr) | drop;
            parity_err <= (parity_err & ~err_clr) | perr_set;
            frame_err  <= (frame_err  & ~err_clr) | ferr_set;

            if ((state == IDLE) || fall || timeout_hit) begin
                tcnt <= TLOAD;
            end else begin
                tcnt <= tcnt - 1'b1;
            end

            if (timeout_hit) begin
                state <= IDLE;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!sdat) begin
                            state  <= DATA;
                            bitcnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg  <= {sdat, shreg[FRAME_DATA_BITS-1:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == LAST_BIT) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= sdat;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
